// File: rtl/dmem_responder.sv
// Word-addressed data RAM for the MEM stage with programmable wait states.
// Optional MISALIGN_TRAP_EN rejects accesses whose byte offset is non-zero.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_mem,
    input  logic        MemWrite_mem,
    input  logic [31:0] alu_res_mem,
    input  logic [31:0] RtData_mem,
    output logic [31:0] Dout_mem,
    output logic        mem_stall,
    output logic        mem_ack,
    output logic        mem_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;

    logic              r_wr;
    logic              r_rd;
    logic              r_mis;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_data;
    logic [31:0]       r_mem [DEPTH];

    logic              w_idle;
    logic              w_req;
    logic              w_start;
    logic              w_enter_done;
    logic              w_wr;
    logic              w_rd;
    logic              w_mis;
    logic              w_trap;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_data;

    assign w_idle  = (r_state == S_IDLE);
    assign w_req   = MemRead_mem | MemWrite_mem;
    assign w_start = w_idle & w_req;

    // With zero wait states the commit happens on the request edge,
    // before the latched copy exists, so take the live inputs then.
    assign w_wr   = w_idle ? MemWrite_mem : r_wr;
    assign w_rd   = w_idle ? (MemRead_mem & ~MemWrite_mem) : r_rd;
    assign w_mis  = w_idle ? (alu_res_mem[1:0] != 2'b00) : r_mis;
    assign w_idx  = w_idle ? alu_res_mem[ADDR_W+1:2] : r_idx;
    assign w_data = w_idle ? RtData_mem : r_data;

`ifdef MISALIGN_TRAP_EN
    assign w_trap = w_mis;
`else
    assign w_trap = 1'b0;
`endif

    assign w_enter_done = (w_next == S_DONE) & reset;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (LP_WAIT == 4'd0) begin
                        w_next = S_DONE;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = LP_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next     = S_DONE;
                    w_cnt_next = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_mis  <= 1'b0;
            r_idx  <= '0;
            r_data <= '0;
        end else if (w_start) begin
            r_wr   <= MemWrite_mem;
            r_rd   <= MemRead_mem & ~MemWrite_mem;
            r_mis  <= (alu_res_mem[1:0] != 2'b00);
            r_idx  <= alu_res_mem[ADDR_W+1:2];
            r_data <= RtData_mem;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_enter_done && w_wr && !w_trap) begin
            r_mem[w_idx] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Dout_mem <= 32'd0;
        end else if (w_enter_done && w_rd && !w_trap) begin
            Dout_mem <= r_mem[w_idx];
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_enter_done) begin
            r_err <= w_trap;
        end
    end

    assign mem_err = (r_state == S_DONE) & r_err;
`else
    assign mem_err = 1'b0;
`endif

    assign mem_ack   = (r_state == S_DONE);
    assign mem_stall = w_start | (r_state == S_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table with read scoreboard on a
// 2-wait-state instance, plus zero-wait back-to-back and reset-abort cases.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rd, wr;
    logic [31:0] addr, wdata, dout;
    logic        stall, ack, err;

    logic        rd0, wr0;
    logic [31:0] addr0, wdata0, dout0;
    logic        stall0, ack0, err0;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(rst_n),
        .MemRead_mem(rd), .MemWrite_mem(wr),
        .alu_res_mem(addr), .RtData_mem(wdata),
        .Dout_mem(dout), .mem_stall(stall),
        .mem_ack(ack), .mem_err(err)
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst_n),
        .MemRead_mem(rd0), .MemWrite_mem(wr0),
        .alu_res_mem(addr0), .RtData_mem(wdata0),
        .Dout_mem(dout0), .mem_stall(stall0),
        .mem_ack(ack0), .mem_err(err0)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        int          stalls;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [int];
    logic [31:0] last_dout;
    logic [31:0] sb [$];
    vec_t        tv [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input vec_t v);
        int   lat;
        int   stalls;
        int   idx;
        logic trap;
        logic is_rd;
        idx  = int'(v.addr[9:2]);
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = (v.addr[1:0] != 2'b00);
`endif
        is_rd = v.rd && !v.wr && !trap;
        if (is_rd) sb.push_back(model[idx]);
        if (v.wr && !trap) model[idx] = v.data;
        @(negedge clk);
        wr = v.wr; rd = v.rd; addr = v.addr; wdata = v.data;
        #1;
        lat = 0; stalls = 0;
        while (!ack && lat < 40) begin
            if (stall) stalls++;
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(v.lat));
        chk("stall_cycles", 32'(stalls), 32'(v.stalls));
        chk("err", {31'd0, err}, {31'd0, trap});
        if (is_rd && sb.size() > 0) begin
            last_dout = sb.pop_front();
            chk("rdata", dout, last_dout);
        end else begin
            chk("dout_hold", dout, last_dout);
        end
        wr = 1'b0; rd = 1'b0;
    endtask

    initial begin
        logic exp_stall [4];
        logic exp_ack [4];

        tv[0]  = '{1'b1, 1'b0, 32'h010, 32'hDEADBEEF, 3, 3};
        tv[1]  = '{1'b0, 1'b1, 32'h010, 32'h0, 3, 3};
        tv[2]  = '{1'b1, 1'b0, 32'h000, 32'h1, 3, 3};
        tv[3]  = '{1'b1, 1'b0, 32'h400, 32'h2, 3, 3};
        tv[4]  = '{1'b0, 1'b1, 32'h000, 32'h0, 3, 3};
        tv[5]  = '{1'b0, 1'b1, 32'h400, 32'h0, 3, 3};
        tv[6]  = '{1'b1, 1'b0, 32'h014, 32'h12345678, 3, 3};
        tv[7]  = '{1'b1, 1'b1, 32'h020, 32'h55, 3, 3};
        tv[8]  = '{1'b0, 1'b1, 32'h020, 32'h0, 3, 3};
        tv[9]  = '{1'b1, 1'b0, 32'h008, 32'h77, 3, 3};
        tv[10] = '{1'b1, 1'b0, 32'h012, 32'hCAFE, 3, 3};
        tv[11] = '{1'b0, 1'b1, 32'h010, 32'h0, 3, 3};
        tv[12] = '{1'b1, 1'b0, 32'h3FC, 32'h0BADF00D, 3, 3};
        tv[13] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 3, 3};

        rst_n = 1'b0;
        rd = 0; wr = 0; addr = 0; wdata = 0;
        rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
        last_dout = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_dout", dout, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_dout0", dout0, 32'd0);
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) access(tv[i]);

        // abort a write of 0xAA to word 2 while it is waiting
        @(negedge clk);
        wr = 1'b1; addr = 32'h8; wdata = 32'hAA;
        @(negedge clk);
        chk("abort_stall_wait", {31'd0, stall}, 32'd1);
        #2;
        rst_n = 1'b0;
        wr = 1'b0;
        #1;
        chk("abort_dout", dout, 32'd0);
        chk("abort_ack", {31'd0, ack}, 32'd0);
        chk("abort_err", {31'd0, err}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_dout = 32'd0;
        access('{1'b0, 1'b1, 32'h008, 32'h0, 3, 3});

        // zero wait states: single write, then a read held high twice
        @(negedge clk);
        wr0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h99;
        #1;
        chk("w0_stall_req", {31'd0, stall0}, 32'd1);
        chk("w0_ack_req", {31'd0, ack0}, 32'd0);
        @(negedge clk);
        chk("w0_ack_done", {31'd0, ack0}, 32'd1);
        chk("w0_stall_done", {31'd0, stall0}, 32'd0);
        wr0 = 1'b0; rd0 = 1'b1;
        exp_stall = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_ack   = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_stall%0d", i), {31'd0, stall0},
                {31'd0, exp_stall[i]});
            chk($sformatf("b2b_ack%0d", i), {31'd0, ack0},
                {31'd0, exp_ack[i]});
            if (exp_ack[i]) chk($sformatf("b2b_data%0d", i), dout0, 32'h99);
        end
        rd0 = 1'b0;
        @(negedge clk);
        chk("b2b_idle_stall", {31'd0, stall0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
